// File: rtl/smp_ctrl.sv
// Debug-halt controller: forwards host accesses to per-core control endpoints and,
// on a breakpoint, halts the remaining cores and raises an interrupt when they stop.
module smp_ctrl #(
    parameter int N_CORES     = 4,
    parameter bit SYNC_EN_RST = 1'b1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   avl_address,
    input  logic                   avl_read,
    input  logic                   avl_write,
    input  logic [31:0]            avl_writedata,
    input  logic [3:0]             avl_byteenable,
    output logic [31:0]            avl_readdata,
    output logic                   avl_waitrequest,
    output logic [N_CORES-1:0]     pe_write,
    output logic [8*N_CORES-1:0]   pe_writedata,
    input  logic [8*N_CORES-1:0]   pe_readdata,
    output logic                   irq
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_HALT_REQ    = 2'd1,
        S_WAIT_HALTED = 2'd2,
        S_DONE        = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [N_CORES-1:0]     pe_write_q, pe_write_d;
    logic [8*N_CORES-1:0]   pe_writedata_q, pe_writedata_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   waitreq_q, waitreq_d;
    logic                   irq_pending_q, irq_pending_d;
    logic                   timeout_q, timeout_d;
    logic                   sync_en_q, sync_en_d;
    logic [3:0]             break_src_q, break_src_d;
    logic [3:0]             halted_mask_q, halted_mask_d;
    logic [3:0]             bp_hist_q, bp_hist_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [3:0]             cpu_halted_s, bp_s, alive_s, bp_rise_s;
    logic [31:0]            rd_ext_s, status_s;
    logic                   all_halted_s, acc_s, wr_s, rd_s;

    // Unpack per-core status lanes into fixed 4-bit vectors; unused cores read as 0.
    always_comb begin
        cpu_halted_s = 4'b0000;
        bp_s         = 4'b0000;
        alive_s      = 4'b0000;
        rd_ext_s     = 32'h0000_0000;
        rd_ext_s[8*N_CORES-1:0] = pe_readdata;
        for (int i = 0; i < N_CORES; i++) begin
            cpu_halted_s[i] = pe_readdata[8*i];
            bp_s[i]         = pe_readdata[8*i+1];
            alive_s[i]      = pe_readdata[8*i+2];
        end
    end

    assign bp_rise_s    = bp_s & ~bp_hist_q;
    assign all_halted_s = &(cpu_halted_s | ~alive_s);
    assign acc_s        = ~waitreq_q & (avl_read | avl_write);
    assign wr_s         = acc_s & avl_write;
    assign rd_s         = acc_s & avl_read;
    assign status_s     = {8'h00, halted_mask_q, break_src_q, 6'h00, timeout_q, irq_pending_q,
                           6'h00, (state_q != S_IDLE), sync_en_q};

    // Host access decode followed by the sync-halt FSM; FSM sets come last so they win over W1C.
    always_comb begin
        state_d        = state_q;
        pe_write_d     = '0;
        pe_writedata_d = pe_writedata_q;
        readdata_d     = readdata_q;
        irq_pending_d  = irq_pending_q;
        timeout_d      = timeout_q;
        sync_en_d      = sync_en_q;
        break_src_d    = break_src_q;
        halted_mask_d  = halted_mask_q;
        cnt_d          = cnt_q;
        bp_hist_d      = bp_s;

        if (wr_s && !avl_address) begin
            pe_write_d     = avl_byteenable[N_CORES-1:0];
            pe_writedata_d = avl_writedata[8*N_CORES-1:0];
        end else if (wr_s && avl_address) begin
            if (avl_byteenable[0]) begin
                sync_en_d = avl_writedata[0];
            end else begin
                sync_en_d = sync_en_q;
            end
            if (avl_byteenable[1] && avl_writedata[8]) begin
                irq_pending_d = 1'b0;
            end else begin
                irq_pending_d = irq_pending_q;
            end
            if (avl_byteenable[1] && avl_writedata[9]) begin
                timeout_d = 1'b0;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            pe_write_d = '0;
        end

        if (rd_s) begin
            readdata_d = avl_address ? status_s : rd_ext_s;
        end else begin
            readdata_d = readdata_q;
        end

        // The halt pulse is launched from HALT_REQ, so it lands in the cycle where
        // any host write held off by waitrequest is only being accepted.
        case (state_q)
            S_IDLE: begin
                if (sync_en_q && (|bp_rise_s)) begin
                    state_d     = S_HALT_REQ;
                    break_src_d = bp_rise_s;
                    cnt_d       = 16'h0000;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT_REQ: begin
                state_d        = S_WAIT_HALTED;
                break_src_d    = break_src_q | bp_rise_s;
                pe_write_d     = ~break_src_q[N_CORES-1:0];
                pe_writedata_d = {N_CORES{8'h02}};
            end
            S_WAIT_HALTED: begin
                break_src_d = break_src_q | bp_rise_s;
                cnt_d       = cnt_q + 16'h0001;
                if (all_halted_s) begin
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_WAIT_HALTED;
                end
            end
            S_DONE: begin
                break_src_d   = break_src_q | bp_rise_s;
                irq_pending_d = 1'b1;
                halted_mask_d = cpu_halted_s;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        waitreq_d = (state_d == S_HALT_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pe_write_q     <= '0;
            pe_writedata_q <= '0;
            readdata_q     <= 32'h0000_0000;
            waitreq_q      <= 1'b0;
            irq_pending_q  <= 1'b0;
            timeout_q      <= 1'b0;
            sync_en_q      <= SYNC_EN_RST;
            break_src_q    <= 4'b0000;
            halted_mask_q  <= 4'b0000;
            bp_hist_q      <= 4'b0000;
            cnt_q          <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pe_write_q     <= pe_write_d;
            pe_writedata_q <= pe_writedata_d;
            readdata_q     <= readdata_d;
            waitreq_q      <= waitreq_d;
            irq_pending_q  <= irq_pending_d;
            timeout_q      <= timeout_d;
            sync_en_q      <= sync_en_d;
            break_src_q    <= break_src_d;
            halted_mask_q  <= halted_mask_d;
            bp_hist_q      <= bp_hist_d;
            cnt_q          <= cnt_d;
        end
    end

    assign avl_readdata    = readdata_q;
    assign avl_waitrequest = waitreq_q;
    assign pe_write        = pe_write_q;
    assign pe_writedata    = pe_writedata_q;
    assign irq             = irq_pending_q;

endmodule
